// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the digit-serial multiplier: digit width, FSM encoding,
// decimal-corrected digit add and digit legality test.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

    // Returns {cout, sum}; a raw sum above 9 is pushed past 15 by +6, which sets bit 4.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                                  input logic cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        if (s > {1'b0, BCD_MAX}) begin
            s = s + 5'd6;
        end
        return s;
    endfunction

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_row.sv
// Combinational DIGITS x 1-digit BCD multiply; each digit product is split into tens and
// units, then the tens are added into the next digit up through a decimal carry chain.
module bcd_digit_row
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 8
) (
    input  logic [DIGIT_W*DIGITS-1:0]     a_i,
    input  logic [DIGIT_W-1:0]            d_i,
    output logic [DIGIT_W*(DIGITS+1)-1:0] pp_o
);

    logic [7:0]         prod;
    logic [DIGIT_W-1:0] units;
    logic [DIGIT_W-1:0] tens_prev;
    logic [4:0]         dsum;
    logic               carry;

    always_comb begin
        pp_o      = '0;
        prod      = '0;
        units     = '0;
        dsum      = '0;
        tens_prev = '0;
        carry     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            prod  = {4'b0, a_i[DIGIT_W*i +: DIGIT_W]} * {4'b0, d_i};
            units = 4'(prod % 8'd10);
            dsum  = bcd_digit_add(units, tens_prev, carry);
            pp_o[DIGIT_W*i +: DIGIT_W] = dsum[3:0];
            carry     = dsum[4];
            tens_prev = 4'(prod / 8'd10);
        end
        // Top digit: tens is at most 8, so adding the carry cannot exceed 9.
        pp_o[DIGIT_W*DIGITS +: DIGIT_W] = tens_prev + {3'b0, carry};
    end

endmodule

// File: rtl/bcd_mult_seq.sv
// Digit-serial BCD multiplier with valid/ready handshake, one multiplier digit per clock.
// Define BCD_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier digits are zero.
module bcd_mult_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DIGIT_W*DIGITS-1:0]     a,
    input  logic [DIGIT_W*DIGITS-1:0]     b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*DIGIT_W*DIGITS-1:0]   p,
    output logic                          err
);

    localparam int unsigned OW = DIGIT_W * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS);

    state_t              state_q, state_d;
    logic [OW-1:0]       a_q, a_d, b_q, b_d;
    logic [2*OW-1:0]     acc_q, acc_d, p_q, p_d;
    logic [CW-1:0]       count_q, count_d;
    logic                err_q, err_d;

    logic [DIGIT_W-1:0]  b_dig;
    logic [OW+DIGIT_W-1:0] pp, sum, acc_hi_ext;
    logic [2*OW-1:0]     step;
    logic [4:0]          dsum;
    logic                carry;
    logic                bad_in;
    logic                last_digit;

    assign b_dig = b_q[DIGIT_W*count_q +: DIGIT_W];

    bcd_digit_row #(
        .DIGITS(DIGITS)
    ) u_row (
        .a_i (a_q),
        .d_i (b_dig),
        .pp_o(pp)
    );

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(a[DIGIT_W*i +: DIGIT_W]) || !is_bcd(b[DIGIT_W*i +: DIGIT_W])) begin
                bad_in = 1'b1;
            end
        end
    end

    // acc_hi + partial product, then shift the whole accumulator right by one digit.
    always_comb begin
        acc_hi_ext = {{DIGIT_W{1'b0}}, acc_q[2*OW-1:OW]};
        sum        = '0;
        dsum       = '0;
        carry      = 1'b0;
        for (int i = 0; i <= DIGITS; i++) begin
            dsum  = bcd_digit_add(acc_hi_ext[DIGIT_W*i +: DIGIT_W], pp[DIGIT_W*i +: DIGIT_W], carry);
            sum[DIGIT_W*i +: DIGIT_W] = dsum[3:0];
            carry = dsum[4];
        end
        step = (2*OW)'({sum, acc_q[OW-1:0]} >> DIGIT_W);
    end

`ifdef BCD_MULT_EARLY_TERM_EN
    always_comb begin
        last_digit = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i > int'(count_q) && b_q[DIGIT_W*i +: DIGIT_W] != '0) begin
                last_digit = 1'b0;
            end
        end
    end
`else
    assign last_digit = (count_q == CW'(DIGITS - 1));
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        count_d = count_q;
        p_d     = p_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    count_d = '0;
                    err_d   = bad_in;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Illegal operands still spend one CALC edge so error latency is one edge.
                if (err_q) begin
                    p_d     = '0;
                    state_d = DONE;
                end else begin
                    acc_d   = step;
                    count_d = count_q + CW'(1);
                    if (last_digit) begin
`ifdef BCD_MULT_EARLY_TERM_EN
                        acc_d = step >> (DIGIT_W * (DIGITS - 1 - int'(count_q)));
`endif
                        p_d     = acc_d;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            count_q <= '0;
            p_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            p_q     <= p_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = p_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_mult_seq.sv
// Randomised bench for bcd_mult_seq at DIGITS = 2, 8 and 16 against a decimal reference model.
module tb_bcd_mult_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  a_bus, b_bus;
    logic [2:0]   in_valid_v;
    logic         out_ready;
    logic [2:0]   in_ready_v, out_valid_v, err_v;
    logic [15:0]  p2;
    logic [63:0]  p8;
    logic [127:0] p16;
    logic [127:0] p_v [3];

    always #5 clk = ~clk;

    bcd_mult_seq #(.DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .p(p2), .err(err_v[0])
    );
    bcd_mult_seq #(.DIGITS(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_bus[31:0]), .b(b_bus[31:0]), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .p(p8), .err(err_v[1])
    );
    bcd_mult_seq #(.DIGITS(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_bus), .b(b_bus), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .p(p16), .err(err_v[2])
    );

    always_comb begin
        p_v[0] = {112'b0, p2};
        p_v[1] = {64'b0, p8};
        p_v[2] = p16;
    end

    int           n_checks = 0;
    int           n_pass   = 0;
    int           active   = -1;
    logic [127:0] exp_p_q [$];
    logic         exp_err_q [$];
    logic [127:0] last_p;
    logic         last_err;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int ndig(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 8 : 16);
    endfunction

    // Decimal reference: BCD -> integer, multiply, integer -> BCD. Bit 128 = illegal digit.
    function automatic logic [128:0] ref_mult(input int nd, input logic [63:0] av,
                                              input logic [63:0] bv);
        logic [127:0] ai, bi, pr, res;
        logic [3:0]   da, db;
        ai  = '0;
        bi  = '0;
        res = '0;
        for (int i = nd - 1; i >= 0; i--) begin
            da = av[4*i +: 4];
            db = bv[4*i +: 4];
            if (da > 4'd9 || db > 4'd9) return {1'b1, 128'b0};
            ai = ai * 128'd10 + 128'(da);
            bi = bi * 128'd10 + 128'(db);
        end
        pr = ai * bi;
        for (int i = 0; i < 2 * nd; i++) begin
            res[4*i +: 4] = 4'(pr % 128'd10);
            pr = pr / 128'd10;
        end
        return {1'b0, res};
    endfunction

    function automatic int exp_lat(input int nd, input logic [63:0] bv, input bit e);
        if (e) return 1;
`ifdef BCD_MULT_EARLY_TERM_EN
        begin
            int hi;
            hi = -1;
            for (int i = 0; i < nd; i++) if (bv[4*i +: 4] != 4'd0) hi = i;
            return (hi < 1) ? 1 : hi + 1;
        end
`else
        return nd;
`endif
    endfunction

    function automatic logic [63:0] rand_bcd(input int nd, input bit allow_bad, input bit short);
        logic [63:0] v;
        int top, idx;
        v   = '0;
        top = short ? int'($urandom_range(0, nd - 1)) : nd - 1;
        for (int i = 0; i <= top; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && $urandom_range(0, 15) == 0) begin
            idx = int'($urandom_range(0, nd - 1));
            v[4*idx +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    // Checks outputs on every cycle they are valid; the front entry is retired on handshake.
    always @(negedge clk) begin
        if (!rst && active >= 0 && out_valid_v[active]) begin
            if (exp_p_q.size() == 0) begin
                check("spurious_out_valid", 128'(out_valid_v[active]), 128'd0);
            end else begin
                check("p", p_v[active], exp_p_q[0]);
                check("err", 128'(err_v[active]), 128'(exp_err_q[0]));
                check("in_ready_low_in_done", 128'(in_ready_v[active]), 128'd0);
                if (out_ready) begin
                    last_p   = p_v[active];
                    last_err = err_v[active];
                    void'(exp_p_q.pop_front());
                    void'(exp_err_q.pop_front());
                end
            end
        end
    end

    task automatic do_op(input int k, input logic [63:0] av, input logic [63:0] bv,
                         input int hold, input bit stray);
        logic [128:0] r;
        int nd, el, lat, guard;
        nd = ndig(k);
        r  = ref_mult(nd, av, bv);
        el = exp_lat(nd, bv, r[128]);
        active = k;
        exp_p_q.push_back(r[127:0]);
        exp_err_q.push_back(r[128]);
        guard = 0;
        while (!in_ready_v[k] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready_v[k]) check("in_ready_timeout", 128'(in_ready_v[k]), 128'd1);
        a_bus = av;
        b_bus = bv;
        in_valid_v[k] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0;
        lat = 0;
        while (!out_valid_v[k] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 128'(lat), 128'(el));
        if (!out_valid_v[k]) begin
            exp_p_q.delete();
            exp_err_q.delete();
            return;
        end
        if (stray) begin
            a_bus = {$urandom, $urandom};
            b_bus = {$urandom, $urandom};
            in_valid_v[k] = 1'b1;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready     = 1'b0;
        in_valid_v[k] = 1'b0;
        check("in_ready_after_handshake", 128'(in_ready_v[k]), 128'd1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [128:0] r;
        logic [63:0]  av, bv;
        int           k;

        rst        = 1'b1;
        in_valid_v = '0;
        out_ready  = 1'b0;
        a_bus      = '0;
        b_bus      = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            check("reset_in_ready", 128'(in_ready_v[i]), 128'd1);
            check("reset_out_valid", 128'(out_valid_v[i]), 128'd0);
            check("reset_p", p_v[i], 128'd0);
            check("reset_err", 128'(err_v[i]), 128'd0);
        end

        r = ref_mult(8, 64'h12345678, 64'h87654321);
        check("model_pin_mul8", r[127:0], 128'h1082152022374638);
        r = ref_mult(2, 64'h99, 64'h99);
        check("model_pin_mul2", r[127:0], 128'h9801);

        do_op(1, 64'h12345678, 64'h87654321, 0, 1'b0);
        check("lit_mul8_p", last_p, 128'h1082152022374638);
        check("lit_mul8_err", 128'(last_err), 128'd0);

        do_op(1, 64'h99999999, 64'h99999999, 5, 1'b1);
        check("lit_max8_p", last_p, 128'h9999999800000001);

        do_op(1, 64'h0000000A, 64'h00000001, 0, 1'b0);
        check("lit_err_p", last_p, 128'd0);
        check("lit_err_flag", 128'(last_err), 128'd1);

        do_op(1, 64'h0, 64'h12345678, 1, 1'b0);
        check("lit_zero_p", last_p, 128'd0);

        do_op(0, 64'h99, 64'h99, 0, 1'b0);
        check("lit_max2_p", last_p, 128'h9801);

        do_op(2, 64'h9999999999999999, 64'h9999999999999999, 2, 1'b1);
        check("lit_max16_p", last_p, 128'h9999999999999998_0000000000000001);

        // Reset three edges into CALC discards the operation.
        active = 1;
        exp_p_q.delete();
        exp_err_q.delete();
        a_bus = 64'h12345678;
        b_bus = 64'h87654321;
        in_valid_v[1] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[1] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midcalc_rst_in_ready", 128'(in_ready_v[1]), 128'd1);
        check("midcalc_rst_out_valid", 128'(out_valid_v[1]), 128'd0);
        check("midcalc_rst_p", p_v[1], 128'd0);

        do_op(1, 64'h2, 64'h3, 0, 1'b0);
        check("lit_after_rst_p", last_p, 128'd6);

        do_op(1, 64'h25, 64'h4, 0, 1'b0);
        check("lit_25x4_p", last_p, 128'h100);
        do_op(1, 64'h12, 64'h00300000, 0, 1'b0);
        check("lit_12x300000_p", last_p, 128'h3600000);

        for (int n = 0; n < 1200; n++) begin
            k  = n % 3;
            av = rand_bcd(ndig(k), 1'b1, $urandom_range(0, 3) == 0);
            bv = rand_bcd(ndig(k), 1'b1, $urandom_range(0, 2) == 0);
            do_op(k, av, bv, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
